// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control plus SPI data-memory wait FSM
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = 16
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemAccessM,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       mem_err
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  logic [1:0] state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic timeout, lwStall, memStall;
  assign timeout = waitCnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign mem_req = state == WAIT;
  assign memStall = (state == IDLE && MemAccessM) || state == WAIT;
  assign lwStall = ResultSrcE == 2'b01 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                     (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
  assign ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                     (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  always_comb
    nextState = (state == IDLE) ? (MemAccessM ? WAIT : IDLE) :
                (state == WAIT) ? ((mem_ack || timeout) ? DONE : WAIT) : IDLE;
  // a frozen pipeline ignores load-use and defers redirects until release
  always_comb begin
    StallF = memStall | lwStall;
    StallD = memStall | lwStall;
    StallE = memStall;
    StallM = memStall;
    FlushW = memStall;
    FlushD = !memStall && PCSrcE;
    FlushE = !memStall && (lwStall || PCSrcE);
  end
  always_ff @(posedge CLK or negedge CLR_N)
    if (!CLR_N) begin
      state <= IDLE;
      waitCnt <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= nextState;
      waitCnt <= (mem_req && !mem_ack && !timeout) ? waitCnt + 1'b1 : '0;
      mem_err <= mem_err | (mem_req && !mem_ack && timeout);
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios plus randomized run against a cycle model
module tb_pipeline_hazard_ctrl;
  localparam int T = 4;
  logic CLK = 1'b0, CLR_N = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ack;
  logic [1:0] ResultSrcE;
  logic mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .mem_ack(mem_ack),
    .mem_req(mem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .mem_err(mem_err)
  );
  task automatic clear_in;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MemAccessM, mem_ack} = '0;
    ResultSrcE = 2'b00;
  endtask
  task automatic test_reset;
    clear_in();
    CLR_N = 1'b0;
    #1;
    checks++;
    if ({mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err} !== 13'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err});
    end
    MemAccessM = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    checks++;
    if ({mem_req, StallF, StallM, FlushW} !== 4'b0111) begin
      failures++;
      $display("FAIL reset_idle_detect got=%b want=0111", {mem_req, StallF, StallM, FlushW});
    end
    @(negedge CLK);
    clear_in();
    CLR_N = 1'b1;
  endtask
  task automatic test_forwarding;
    @(negedge CLK);
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1000) begin
      failures++;
      $display("FAIL fwd_m_priority got=%b want=1000", {ForwardAE, ForwardBE});
    end
    RdM = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      failures++;
      $display("FAIL fwd_w got=%b want=01", ForwardAE);
    end
    Rs2E = 5; RegWriteW = 0; RdM = 5; RegWriteM = 1; Rs1E = 6;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) begin
      failures++;
      $display("FAIL fwd_b_m got=%b want=0010", {ForwardAE, ForwardBE});
    end
    clear_in();
  endtask
  task automatic test_load_use;
    @(negedge CLK);
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
      failures++;
      $display("FAIL load_use got=%b want=1110", {StallF, StallD, FlushE, FlushD});
    end
    RdE = 0; Rs2D = 0;
    #1;
    checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b0000) begin
      failures++;
      $display("FAIL load_use_x0 got=%b want=0000", {StallF, StallD, FlushE, FlushD});
    end
    RdE = 3; Rs1D = 3; PCSrcE = 1;
    #1;
    checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1111) begin
      failures++;
      $display("FAIL load_use_branch got=%b want=1111", {StallF, StallD, FlushE, FlushD});
    end
    clear_in();
  endtask
  task automatic test_branch;
    @(negedge CLK);
    PCSrcE = 1;
    #1;
    checks++;
    if ({FlushD, FlushE, StallF, StallD, StallE, StallM} !== 6'b110000) begin
      failures++;
      $display("FAIL branch_flush got=%b want=110000", {FlushD, FlushE, StallF, StallD, StallE, StallM});
    end
    @(negedge CLK);
    PCSrcE = 0;
    #1;
    checks++;
    if ({FlushD, FlushE} !== 2'b00) begin
      failures++;
      $display("FAIL branch_release got=%b want=00", {FlushD, FlushE});
    end
  endtask
  task automatic test_mem_access;
    int frozen = 0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge CLK);
      MemAccessM = c <= 4;
      mem_ack = c == 3;
      #1;
      frozen += int'(StallF);
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushW} !== {5{c <= 3}} || mem_req !== (c >= 1 && c <= 3)) begin
        failures++;
        $display("FAIL mem_cycle%0d got stalls=%b req=%b want stalls=%b req=%b", c,
                 {StallF, StallD, StallE, StallM, FlushW}, mem_req, {5{c <= 3}}, c >= 1 && c <= 3);
      end
    end
    checks++;
    if (frozen != 4) begin
      failures++;
      $display("FAIL mem_freeze_len got=%0d want=4", frozen);
    end
    clear_in();
  endtask
  task automatic test_timeout;
    int reqs = 0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge CLK);
      MemAccessM = c <= 5;
      #1;
      reqs += int'(mem_req);
      checks++;
      if (mem_req !== (c >= 1 && c <= 4) || mem_err !== (c >= 5)) begin
        failures++;
        $display("FAIL timeout_cycle%0d got req=%b err=%b want req=%b err=%b", c, mem_req, mem_err, c >= 1 && c <= 4, c >= 5);
      end
    end
    checks++;
    if (reqs != T) begin
      failures++;
      $display("FAIL timeout_req_len got=%0d want=%0d", reqs, T);
    end
    @(negedge CLK);
    CLR_N = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_clear got=%b want=0", mem_err);
    end
    CLR_N = 1'b1;
    clear_in();
  endtask
  task automatic test_reset_mid_wait;
    for (int c = 0; c <= 4; c++) begin
      @(negedge CLK);
      MemAccessM = c <= 3;
      mem_ack = c == 2;
      PCSrcE = c >= 1 && c <= 3;
      #1;
      checks++;
      if ({FlushD, FlushE} !== {2{c == 3}}) begin
        failures++;
        $display("FAIL branch_in_wait_cycle%0d got=%b want=%b", c, {FlushD, FlushE}, {2{c == 3}});
      end
    end
    clear_in();
    @(negedge CLK);
    MemAccessM = 1;
    @(negedge CLK);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_entry got=%b want=1", mem_req);
    end
    CLR_N = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_async got=%b want=0", mem_req);
    end
    #1;
    CLR_N = 1'b1;
    MemAccessM = 0;
    mem_ack = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1;
      checks++;
      if ({mem_req, StallF, mem_err} !== 3'b000) begin
        failures++;
        $display("FAIL rst_stale_ack%0d got=%b want=000", c, {mem_req, StallF, mem_err});
      end
    end
    clear_in();
  endtask
  function automatic logic [1:0] fwd_exp(input logic [4:0] rs, input logic wm, input logic [4:0] rm,
                                         input logic ww, input logic [4:0] rw);
    if (rs == 0) return 2'b00;
    if (wm && rm == rs) return 2'b10;
    if (ww && rw == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic test_random;
    int phase = 0, waited = 0;
    logic err_exp = 0, freeze, lw;
    logic [12:0] exp_v, got_v;
    @(negedge CLK);
    CLR_N = 1'b0;
    #1;
    CLR_N = 1'b1;
    for (int n = 0; n < 500; n++) begin
      @(negedge CLK);
      {Rs1D, Rs2D, Rs1E, Rs2E} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      {RdE, RdM, RdW} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      {RegWriteM, RegWriteW} = 2'($urandom);
      ResultSrcE = 2'($urandom);
      PCSrcE = $urandom_range(0, 3) == 0;
      MemAccessM = $urandom_range(0, 3) == 0;
      mem_ack = $urandom_range(0, 4) == 0;
      #1;
      freeze = (phase == 0 && MemAccessM) || phase == 1;
      lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      exp_v = {phase == 1, {2{freeze || lw}}, {2{freeze}}, !freeze && PCSrcE, !freeze && (lw || PCSrcE), freeze,
               fwd_exp(Rs1E, RegWriteM, RdM, RegWriteW, RdW), fwd_exp(Rs2E, RegWriteM, RdM, RegWriteW, RdW), err_exp};
      got_v = {mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL random_step%0d got=%b want=%b", n, got_v, exp_v);
      end
      @(posedge CLK);
      if (phase == 0) begin
        if (MemAccessM) begin phase = 1; waited = 0; end
      end else if (phase == 1) begin
        if (mem_ack) phase = 2;
        else if (waited == T - 1) begin phase = 2; err_exp = 1; end
        else waited++;
      end else phase = 0;
    end
    clear_in();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_access();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
